// File: rtl/mem_req_responder.sv
// Word-addressed backing store behind a req/gnt/rvalid port with fixed latency and in-order responses.
// Optional range checking with error responses is enabled by defining MEM_RESP_ERR_EN.
module mem_req_responder #(
  parameter int unsigned          AddrWidth = 64,
  parameter int unsigned          DataWidth = 64,
  parameter int unsigned          TidWidth  = 2,
  parameter logic [AddrWidth-1:0] BaseAddr  = AddrWidth'(64'h8000_0000),
  parameter int unsigned          MemWords  = 1024,
  parameter int unsigned          Latency   = 1,
  parameter int unsigned          RespDepth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic                   we_i,
  input  logic [DataWidth/8-1:0] be_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [TidWidth-1:0]    tid_i,
  output logic                   rvalid_o,
  input  logic                   rready_i,
  output logic [DataWidth-1:0]   rdata_o,
  output logic [TidWidth-1:0]    rtid_o,
  output logic                   rerr_o
);

  localparam int unsigned    NumBytes = DataWidth / 8;
  localparam int unsigned    ByteLsb  = $clog2(NumBytes);
  localparam int unsigned    IdxW     = $clog2(MemWords);
  localparam int unsigned    CntW     = $clog2(RespDepth + 1);
  localparam int unsigned    PtrW     = $clog2(RespDepth);
  localparam int unsigned    TupW     = DataWidth + TidWidth + 1;
  localparam logic [CntW-1:0] DepthC  = CntW'(RespDepth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(RespDepth - 1);

  logic [DataWidth-1:0] mem_q [MemWords];

  logic [AddrWidth-1:0] off;
  logic [IdxW-1:0]      idx;
  logic                 acc, pop, acc_err;
  logic [DataWidth-1:0] acc_rdata;
  logic [TupW-1:0]      acc_tup;
  logic                 push;
  logic [TupW-1:0]      push_tup;
  logic                 unused_off;

  logic [CntW-1:0] inflight_q, inflight_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [TupW-1:0] fifo_q [RespDepth];
  logic [TupW-1:0] head;

  assign off        = addr_i - BaseAddr;
  assign idx        = off[ByteLsb +: IdxW];
  assign unused_off = ^{off[AddrWidth-1:ByteLsb+IdxW], off[ByteLsb-1:0]};

`ifdef MEM_RESP_ERR_EN
  localparam logic [AddrWidth-1:0] MemBytes = AddrWidth'(MemWords * NumBytes);
  // Addresses below BaseAddr wrap to huge offsets and fail the same compare.
  assign acc_err = (off >= MemBytes);
`else
  assign acc_err = 1'b0;
`endif

  // Gated by reset so no grant is seen while the block is held in reset.
  assign gnt_o     = rst_ni && (inflight_q < DepthC);
  assign acc       = req_i && gnt_o;
  assign pop       = rvalid_o && rready_i;
  assign acc_rdata = (we_i || acc_err) ? '0 : mem_q[idx];
  assign acc_tup   = {acc_rdata, tid_i, acc_err};

  always_ff @(posedge clk_i) begin
    if (acc && we_i && !acc_err) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (be_i[i]) mem_q[idx][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  if (Latency > 1) begin : g_pipe
    localparam int unsigned Stages = Latency - 1;
    logic [Stages-1:0] vld_q;
    logic [TupW-1:0]   tup_q [Stages];

    // Free-running shift; grant already bounds total occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q <= '0;
        for (int i = 0; i < Stages; i++) tup_q[i] <= '0;
      end else begin
        vld_q[0] <= acc;
        tup_q[0] <= acc_tup;
        for (int i = 1; i < Stages; i++) begin
          vld_q[i] <= vld_q[i-1];
          tup_q[i] <= tup_q[i-1];
        end
      end
    end

    assign push     = vld_q[Stages-1];
    assign push_tup = tup_q[Stages-1];
  end else begin : g_nopipe
    assign push     = acc;
    assign push_tup = acc_tup;
  end

  always_comb begin
    inflight_d = inflight_q;
    cnt_d      = cnt_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    case ({acc, pop})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: ;
    endcase
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
    if (push) wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
    if (pop)  rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= '0;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q] <= push_tup;
  end

  // Outputs are masked by rvalid so the storage array needs no reset.
  assign head     = fifo_q[rptr_q];
  assign rvalid_o = (cnt_q != '0);
  assign rdata_o  = rvalid_o ? head[TupW-1 -: DataWidth] : '0;
  assign rtid_o   = rvalid_o ? head[1 +: TidWidth] : '0;
  assign rerr_o   = rvalid_o & head[0];

endmodule

// File: doc/mem_req_responder.md
Name: mem_req_responder

Overview:
- Memory-side responder for the core's cache memory request port (req/gnt/rvalid with transaction IDs).
- Models the cached DRAM region behind the write-back data cache: a word-addressed backing store with configurable response latency, in-order responses, and a bounded number of outstanding transactions.
- Used as the far end of the request interface in block-level and subsystem benches, and as a synthesizable scratchpad.

Parameters:
- AddrWidth, 64, request address width.
- DataWidth, 64, data word width; must be a power of two ≥ 32.
- TidWidth, 2, transaction ID width.
- BaseAddr, 64'h8000_0000, byte address of word 0.
- MemWords, 1024, backing-store depth in words; power of two.
- Latency, 1, cycles from accept edge to response visibility; legal range 1..4.
- RespDepth, 8, maximum outstanding transactions (latency pipeline plus response FIFO).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  request valid.
- gnt_o  out  1  request grant; accept occurs when req_i && gnt_o.
- addr_i  in  AddrWidth  byte address.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  DataWidth/8  write byte enables.
- wdata_i  in  DataWidth  write data.
- tid_i  in  TidWidth  transaction ID.
- rvalid_o  out  1  response valid.
- rready_i  in  1  response consumed when rvalid_o && rready_i.
- rdata_o  out  DataWidth  read data; 0 for write responses.
- rtid_o  out  TidWidth  echoed ID.
- rerr_o  out  1  access error.

Behaviour:
- Single clock domain, clk_i. rst_ni is asynchronous and active-low.
- Reset values: gnt_o = 0 while rst_ni is low, otherwise follows the grant rule. rvalid_o = 0, rdata_o = 0, rtid_o = 0, rerr_o = 0. Inflight counter = 0. Pipeline and FIFO are empty.
- The backing store is not reset.
- Index = ((addr_i − BaseAddr) >> log2(DataWidth/8)) mod MemWords. Subtraction is AddrWidth-bit, unsigned, and wraps. Low address bits below word size are ignored.
- Grant: gnt_o = (inflight < RespDepth). Combinational from state only; it never depends on req_i.
- Inflight counter:
  - +1 on accept, −1 on pop, unchanged when both occur in the same cycle.
  - Width is clog2(RespDepth+1).
  - Never exceeds RespDepth and never underflows.
- Accept (edge k):
  - Write: bytes with be_i[i] = 1 are updated at edge k; all other bytes are kept. be_i = 0 is legal and performs no update but still returns a response.
  - Read: the word is sampled at edge k.
  - A read accepted at edge k+1 or later returns data written at edge k or earlier (read-after-write ordering preserved).
- Latency pipeline: the tuple {rdata, tid, err} passes through Latency−1 additional stages. The stages always advance; no stall is needed, because grant limits total occupancy to RespDepth.
- Response FIFO:
  - Depth is RespDepth, first-word fall-through.
  - With the FIFO empty, rvalid_o asserts in the cycle following edge k+Latency−1. For Latency = 1, that is the cycle directly after the accept edge.
- Responses leave in strict acceptance order. rtid_o equals the accepted tid_i.
- While rvalid_o && !rready_i, rdata_o, rtid_o and rerr_o hold stable.
- Boundaries:
  - FIFO full and inflight = RespDepth → gnt_o = 0.
  - A pop in the same cycle does not raise gnt_o until the next cycle.
  - Counter and FIFO pointers wrap modulo depth.
- Reset asserted mid-operation: all in-flight responses are dropped and rvalid_o clears immediately (asynchronously). Writes already performed remain in the store.

Optional Feature:
- Macro MEM_RESP_ERR_EN.
- Defined:
  - An address outside [BaseAddr, BaseAddr + MemWords·DataWidth/8) is an error.
  - No write is performed; the response has rdata_o = 0 and rerr_o = 1.
  - Latency and ordering are identical to a normal access.
- Undefined: rerr_o is tied to 0, and out-of-range addresses alias via the mod-MemWords index.

Test Plan:
- Latency = 1, rready_i = 1: write 64'hDEAD_BEEF_0123_4567 to 0x8000_0010 with be = 8'hFF, then read 0x8000_0010 with tid 2 → rvalid_o one cycle after the read accept, rdata_o = 64'hDEAD_BEEF_0123_4567, rtid_o = 2.
- Partial write: be = 8'h0F with wdata 0, applied over 64'hFFFF_FFFF_FFFF_FFFF → read returns 64'hFFFF_FFFF_0000_0000.
- Backpressure: rready_i = 0, issue 10 back-to-back reads (RespDepth = 8) → exactly 8 accepted, then gnt_o = 0. Raise rready_i → 8 responses with tids in issue order. gnt_o reasserts the cycle after the first pop.
- Latency = 3: a read accepted at edge k → rvalid_o first high in the cycle after edge k+2. Back-to-back reads sustain one response per cycle.
- Reset asserted with 4 responses pending → rvalid_o = 0 immediately, gnt_o = 1 after release, and previously written data is still readable.
- MEM_RESP_ERR_EN defined: write to 0x7FFF_FFF8 → rerr_o = 1, rdata_o = 0. A read of index MemWords−1 is unaffected. Undefined: the same write aliases and rerr_o stays 0.
